// File: rtl/io1bit_serial_ctrl_if.sv
// ----------------------------------------------------------------------------
// io1bit_serial_ctrl_if
//
// Purpose:
//   Bundles the host handshake and pad-cell signals of the single-wire serial
//   engine so that the engine and its surroundings share one port.
//
// Signals:
//   tx_valid  host offers a transmit word
//   tx_data   transmit word (DATA_W bits)
//   tx_ready  engine can accept a word this cycle
//   rx_valid  one-cycle pulse, received word valid
//   rx_data   last received word (DATA_W bits)
//   rx_err    qualifies rx_valid: framing or parity error
//   f2p       drive value towards the pad cell
//   mode      pad output enable (1 = drive pad)
//   p2f       pad readback, asynchronous to the engine clock
//
// Modports:
//   master    host plus pad side (drives tx_valid, tx_data, p2f)
//   slave     the serial engine
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface io1bit_serial_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_err;
    logic              f2p;
    logic              mode;
    logic              p2f;

    modport master (
        output tx_valid, tx_data, p2f,
        input  tx_ready, rx_valid, rx_data, rx_err, f2p, mode
    );

    modport slave (
        input  tx_valid, tx_data, p2f,
        output tx_ready, rx_valid, rx_data, rx_err, f2p, mode
    );
endinterface

// File: rtl/io1bit_serial_ctrl.sv
// ----------------------------------------------------------------------------
// io1bit_serial_ctrl
//
// Purpose:
//   Half-duplex, single-wire UART-style engine sitting in front of a 1-bit
//   bidirectional pad cell. The line idles high. A frame is a low start bit,
//   DATA_W data bits LSB first, an optional even-parity bit and a high stop
//   bit, each held BIT_CYC clocks. After transmitting, the pad is released
//   for TURN_CYC clocks before the engine goes idle again.
//
// Parameters:
//   DATA_W    payload bits per frame (>= 1)
//   BIT_CYC   clocks per serial bit (even, >= 4)
//   TURN_CYC  bus-release clocks after a transmit frame (>= 1)
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset
//   bus       io1bit_serial_ctrl_if.slave (host handshake and pad signals)
//
// Configuration:
//   IO1BIT_SERIAL_CTRL_PARITY_EN  when defined, an even-parity bit follows
//                                 the data bits in both directions and a
//                                 receive parity mismatch sets rx_err.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module io1bit_serial_ctrl #(
    parameter int DATA_W   = 8,
    parameter int BIT_CYC  = 4,
    parameter int TURN_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    io1bit_serial_ctrl_if.slave bus
);

`ifdef IO1BIT_SERIAL_CTRL_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // The shift register holds everything after the start bit: data,
    // optional parity and stop.
    localparam int SH_W       = DATA_W + PAR_W + 1;
    localparam int FRAME_BITS = SH_W + 1;
    localparam int CYC_MAX    = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
    localparam int CYC_W      = $clog2(CYC_MAX);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] HALF_LAST  = CYC_W'(BIT_CYC / 2 - 1);
    localparam logic [CYC_W-1:0] TURN_LAST  = CYC_W'(TURN_CYC - 1);
    localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] RX_LAST    = BIT_W'(SH_W);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        TURN,
        RX
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_syncPrev;
    logic [CYC_W-1:0]  r_cycCnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [SH_W-1:0]   r_shift;
    logic              r_f2p;
    logic              r_mode;
    logic              r_rxValid;
    logic [DATA_W-1:0] r_rxData;
    logic              r_rxErr;

    logic [CYC_W-1:0]  w_cycCnt;
    logic [BIT_W-1:0]  w_bitCnt;
    logic [SH_W-1:0]   w_shift;
    logic              w_f2p;
    logic              w_mode;
    logic              w_rxValid;
    logic [DATA_W-1:0] w_rxData;
    logic              w_rxErr;

    logic              w_txReady;
    logic              w_accept;
    logic              w_fall;
    logic [SH_W-1:0]   w_txLoad;
    logic [SH_W-1:0]   w_rxFrame;
    logic              w_rxBad;

    // Handshake and edge detect. Ready is masked while reset is held so the
    // host never sees an acceptance during reset.
    assign w_txReady = (r_state == IDLE) && !reset;
    assign w_accept  = bus.tx_valid && w_txReady;
    assign w_fall    = r_syncPrev && !r_sync2;

    // Receive frame as it will look once the current line sample is shifted
    // in; only meaningful at the final (stop) sample.
    assign w_rxFrame = {r_sync2, r_shift[SH_W-1:1]};

`ifdef IO1BIT_SERIAL_CTRL_PARITY_EN
    assign w_txLoad = {1'b1, ^bus.tx_data, bus.tx_data};
    assign w_rxBad  = !w_rxFrame[SH_W-1] || (^w_rxFrame[DATA_W:0]);
`else
    assign w_txLoad = {1'b1, bus.tx_data};
    assign w_rxBad  = !w_rxFrame[SH_W-1];
`endif

    // State register for the IDLE/TX/TURN/RX controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and datapath decode. TX drives the frame out of the shift
    // register one bit per BIT_CYC clocks. RX first rechecks the start bit at
    // its centre (glitch reject), then samples every following bit centre,
    // shifting new bits in from the top so the first data bit ends up at
    // bit 0. Transmit acceptance has priority over a falling edge in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_cycCnt    = r_cycCnt;
        w_bitCnt    = r_bitCnt;
        w_shift     = r_shift;
        w_f2p       = r_f2p;
        w_mode      = r_mode;
        w_rxValid   = 1'b0;
        w_rxData    = r_rxData;
        w_rxErr     = r_rxErr;

        case (r_state)
            IDLE: begin
                w_mode = 1'b0;
                w_f2p  = 1'b1;
                if (w_accept) begin
                    w_nextState = TX;
                    w_shift     = w_txLoad;
                    w_f2p       = 1'b0;
                    w_mode      = 1'b1;
                    w_cycCnt    = '0;
                    w_bitCnt    = '0;
                end else if (w_fall) begin
                    w_nextState = RX;
                    w_cycCnt    = '0;
                    w_bitCnt    = '0;
                end
            end

            TX: begin
                if (r_cycCnt == BIT_LAST) begin
                    w_cycCnt = '0;
                    if (r_bitCnt == FRAME_LAST) begin
                        w_nextState = TURN;
                        w_mode      = 1'b0;
                        w_f2p       = 1'b1;
                    end else begin
                        w_bitCnt = r_bitCnt + 1'b1;
                        w_f2p    = r_shift[0];
                        w_shift  = {1'b1, r_shift[SH_W-1:1]};
                    end
                end else begin
                    w_cycCnt = r_cycCnt + 1'b1;
                end
            end

            TURN: begin
                w_mode = 1'b0;
                w_f2p  = 1'b1;
                if (r_cycCnt == TURN_LAST) begin
                    w_nextState = IDLE;
                    w_cycCnt    = '0;
                end else begin
                    w_cycCnt = r_cycCnt + 1'b1;
                end
            end

            RX: begin
                if (r_bitCnt == '0) begin
                    if (r_cycCnt == HALF_LAST) begin
                        w_cycCnt = '0;
                        if (r_sync2) begin
                            w_nextState = IDLE;
                        end else begin
                            w_bitCnt = BIT_W'(1);
                        end
                    end else begin
                        w_cycCnt = r_cycCnt + 1'b1;
                    end
                end else if (r_cycCnt == BIT_LAST) begin
                    w_cycCnt = '0;
                    w_shift  = w_rxFrame;
                    if (r_bitCnt == RX_LAST) begin
                        w_nextState = IDLE;
                        w_bitCnt    = '0;
                        w_rxValid   = 1'b1;
                        w_rxData    = w_rxFrame[DATA_W-1:0];
                        w_rxErr     = w_rxBad;
                    end else begin
                        w_bitCnt = r_bitCnt + 1'b1;
                    end
                end else begin
                    w_cycCnt = r_cycCnt + 1'b1;
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers and the pad-readback synchronizer. The synchronizer
    // and its edge-detect history reset to the idle-high line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_syncPrev <= 1'b1;
            r_cycCnt   <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_f2p      <= 1'b1;
            r_mode     <= 1'b0;
            r_rxValid  <= 1'b0;
            r_rxData   <= '0;
            r_rxErr    <= 1'b0;
        end else begin
            r_sync1    <= bus.p2f;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            r_cycCnt   <= w_cycCnt;
            r_bitCnt   <= w_bitCnt;
            r_shift    <= w_shift;
            r_f2p      <= w_f2p;
            r_mode     <= w_mode;
            r_rxValid  <= w_rxValid;
            r_rxData   <= w_rxData;
            r_rxErr    <= w_rxErr;
        end
    end

    assign bus.tx_ready = w_txReady;
    assign bus.rx_valid = r_rxValid;
    assign bus.rx_data  = r_rxData;
    assign bus.rx_err   = r_rxErr;
    assign bus.f2p      = r_f2p;
    assign bus.mode     = r_mode;

endmodule

// File: doc/io1bit_serial_ctrl.md
IO1BIT_SERIAL_CTRL -- requirements
Module: io1bit_serial_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame (>=1).
REQ-002 Parameter: BIT_CYC, default 4, clocks per serial bit (even, >=4).
REQ-003 Parameter: TURN_CYC, default 2, bus-release clocks after a transmit frame (>=1).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: tx_valid  input  1  host offers a transmit word.
REQ-007 Port: tx_data  input  DATA_W  transmit word, captured on accept.
REQ-008 Port: tx_ready  output  1  block can accept a word this cycle.
REQ-009 Port: rx_valid  output  1  one-cycle pulse: received word valid.
REQ-010 Port: rx_data  output  DATA_W  last received word, held until next rx_valid.
REQ-011 Port: rx_err  output  1  qualifies rx_valid: framing (or parity) error.
REQ-012 Port: f2p  output  1  drive value to pad cell.
REQ-013 Port: mode  output  1  pad output enable (1 = drive pad).
REQ-014 Port: p2f  input  1  pad readback, asynchronous to clk.

Function
REQ-015 SHALL be a half-duplex single-wire UART-style engine upstream of the 1-bit pad cell; line idles high.
REQ-016 SHALL pass p2f through a 2-flop synchronizer; all receive logic uses the synchronized value only.
REQ-017 SHALL implement states IDLE, TX, TURN, RX; tx_ready = 1 only in IDLE.
REQ-018 Transfer is accepted when tx_valid & tx_ready; tx_data is registered in the same cycle.
REQ-019 Frame: start bit 0, DATA_W bits LSB-first, stop bit 1; each bit is held exactly BIT_CYC clocks.
REQ-020 TX: mode = 1 from the cycle after accept through the last stop-bit cycle; f2p carries the frame bits.
REQ-021 After the stop bit, SHALL enter TURN with mode = 0 and f2p = 1 for TURN_CYC cycles, then return to IDLE.
REQ-022 IDLE/TURN: mode = 0. In TURN, synchronized p2f SHALL be ignored.
REQ-023 IDLE: a falling edge on synchronized p2f enters RX unless a transmit is accepted in the same cycle; transmit wins.
REQ-024 RX: recheck the start bit BIT_CYC/2 cycles after the edge; if it is high, return to IDLE silently (glitch reject).
REQ-025 RX: sample the data bits and the stop bit at bit centres, i.e. every BIT_CYC cycles after the start recheck.
REQ-026 After the stop-bit sample: rx_valid pulses for 1 cycle, rx_data updates, rx_err = (stop == 0); then IDLE.
REQ-027 A new frame start is accepted on the cycle immediately after rx_valid.
REQ-028 Bit and cycle counters SHALL be sized to hold DATA_W+2 (or +3) and BIT_CYC-1 without wrap.

Reset
REQ-029 While reset = 1: state = IDLE, mode = 0, f2p = 1, tx_ready = 0, rx_valid = 0, rx_err = 0, rx_data = 0, synchronizer = 1, counters = 0.
REQ-030 tx_ready SHALL rise the first cycle after reset deasserts.
REQ-031 Reset mid-frame SHALL abort immediately; mode = 0 the next cycle; no partial rx_valid.

Configuration
REQ-032 Macro IO1BIT_SERIAL_CTRL_PARITY_EN defined: an even-parity bit follows the data bits in both directions. A receive parity mismatch sets rx_err.
REQ-033 Macro undefined: no parity bit; frame length is exactly DATA_W+2 bits.

Verification
REQ-034 Reset, then tx_data=8'hA5 accepted -> mode=1 for 40 cycles; f2p = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; then mode=0 for 2 cycles; then tx_ready=1.
REQ-035 Drive p2f with frame 8'h3C at BIT_CYC=4 -> single rx_valid, rx_data=8'h3C, rx_err=0.
REQ-036 Frame with stop bit 0 -> rx_valid with rx_err=1; a back-to-back second valid frame is received correctly.
REQ-037 1-cycle low glitch on p2f in IDLE -> no rx_valid; tx_ready returns to 1 within BIT_CYC/2+3 cycles.
REQ-038 tx_valid coincident with a p2f falling edge -> TX frame sent, no rx_valid; reset asserted mid-TX -> mode=0 the next cycle.
REQ-039 With PARITY_EN, send 8'h01 -> parity bit 1 on the line; receive 8'h01 with parity 0 -> rx_err=1.
